// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode, status and memory-stage FSM state constants
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/mem_access_decode.sv
// mem_access_decode: maps icode and operands to memory access type, address and write data
module mem_access_decode
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valP,
  output logic              is_mem,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);
  always_comb begin
    we = icode == IRMMOVQ || icode == ICALL || icode == IPUSHQ;
    is_mem = we || icode == IMRMOVQ || icode == IRET || icode == IPOPQ;
    addr = (icode == IRET || icode == IPOPQ) ? valA : valE;
    wdata = DATA_W'(icode == ICALL ? valP : valA);
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: Y86-64 memory-stage controller with checked, timed-out req/ack access
module mem_stage_ctrl
  import y86_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_BYTES   = 8192,
  parameter bit CHECK_ALIGN = 1'b1,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [2:0]        stat_in,
  input  logic [ADDR_W-1:0] valE,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valP,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode_out,
  output logic [DATA_W-1:0] valM,
  output logic [2:0]        stat_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              d_is_mem, d_we, mem_op, chk_fail, timeout;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  mem_access_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dec (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .is_mem(d_is_mem),
    .we    (d_we),
    .addr  (d_addr),
    .wdata (d_wdata)
  );
  // Bound compare is against the last legal base so a huge address cannot wrap into range
  assign chk_fail = d_addr > ADDR_W'(MEM_BYTES - BYTES) ||
                    (CHECK_ALIGN && (d_addr & ADDR_W'(BYTES - 1)) != '0);
  assign mem_op   = d_is_mem && stat_in == SAOK;
  assign timeout  = cnt == CNT_W'(TIMEOUT - 1);
  assign in_ready  = state == ST_IDLE;
  assign mem_req   = state == ST_ACCESS;
  assign out_valid = state == ST_RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      icode_out <= '0;
      valM      <= '0;
      stat_out  <= SAOK;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          icode_out <= icode;
          mem_we    <= mem_op && d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          valM      <= '0;
          cnt       <= '0;
          stat_out  <= mem_op && chk_fail ? SADR : stat_in;
          state     <= mem_op && !chk_fail ? ST_ACCESS : ST_RESP;
        end
        ST_ACCESS: if (mem_ack) begin
          stat_out <= mem_err ? SADR : SAOK;
          valM     <= !mem_err && !mem_we ? mem_rdata : '0;
          state    <= ST_RESP;
        end else if (timeout) begin
          stat_out <= SADR;
          state    <= ST_RESP;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        ST_RESP: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
